// File: rtl/stream_arb2_pkg.sv
// Shared definitions for the two-requester packet arbiter.
package stream_arb2_pkg;

  localparam int DATA_BYTES_DEF = 16;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

  // One-hot owner for a given state; idle (and any illegal code) owns nothing.
  function automatic logic [1:0] grant_of(arb_state_e s);
    case (s)
      BUSY0:   grant_of = 2'b01;
      BUSY1:   grant_of = 2'b10;
      default: grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/stream_arb2_if.sv
// Byte-enabled packet stream with valid/ready handshake.
interface stream_arb2_if
  import stream_arb2_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF
) ();

  logic [DATA_BYTES*8-1:0] data;
  logic                    last;
  logic [DATA_BYTES-1:0]   keep;
  logic                    valid;
  logic                    ready;

  modport master (output data, last, keep, valid, input  ready);
  modport slave  (input  data, last, keep, valid, output ready);

endinterface

// File: rtl/stream_arb2_out_reg.sv
// One-entry valid/ready output register; data, keep and last travel as a
// single payload word so they always update together.
module arb_out_reg
  import stream_arb2_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  stream_arb2_if.slave  in_s,
  stream_arb2_if.master out_m
);

  localparam int W = DATA_BYTES*9+1;

  logic [W-1:0] payload_q, payload_d;
  logic         valid_q, valid_d;
  logic         load;

  // Accept whenever the slot is empty or is being drained this cycle
  assign in_s.ready = ~valid_q | out_m.ready;
  assign load       = in_s.valid & in_s.ready;

  // Load beats back to back; drop valid only when drained with nothing new
  always_comb begin
    payload_d = payload_q;
    valid_d   = valid_q;
    if (load) begin
      payload_d = {in_s.data, in_s.keep, in_s.last};
      valid_d   = 1'b1;
    end else if (out_m.ready) begin
      valid_d   = 1'b0;
    end
  end

  // Register state; reset discards any stalled beat
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      payload_q <= payload_d;
      valid_q   <= valid_d;
    end
  end

  assign out_m.data  = payload_q[W-1 -: DATA_BYTES*8];
  assign out_m.keep  = payload_q[DATA_BYTES:1];
  assign out_m.last  = payload_q[0];
  assign out_m.valid = valid_q;

endmodule

// File: rtl/stream_arb2.sv
// Two-requester packet arbiter: alternates ownership per packet, merges the
// winner into a single registered output stream and counts packets per port.
module stream_arb2
  import stream_arb2_pkg::*;
#(
  parameter int DATA_BYTES = DATA_BYTES_DEF,
  parameter int CNT_BITS   = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DATA_BYTES*8-1:0] s0_data,
  input  logic                    s0_last,
  input  logic [DATA_BYTES-1:0]   s0_keep,
  input  logic                    s0_valid,
  output logic                    s0_ready,
  input  logic [DATA_BYTES*8-1:0] s1_data,
  input  logic                    s1_last,
  input  logic [DATA_BYTES-1:0]   s1_keep,
  input  logic                    s1_valid,
  output logic                    s1_ready,
  output logic [DATA_BYTES*8-1:0] out_data,
  output logic                    out_last,
  output logic [DATA_BYTES-1:0]   out_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              grant,
  output logic [CNT_BITS-1:0]     pkt_cnt0,
  output logic [CNT_BITS-1:0]     pkt_cnt1
);

  stream_arb2_if #(.DATA_BYTES(DATA_BYTES)) mux_s ();
  stream_arb2_if #(.DATA_BYTES(DATA_BYTES)) out_s ();

  arb_state_e          state_q, state_d;
  logic                last_served_q, last_served_d;
  logic [1:0]          grant_q, grant_d;
  logic [CNT_BITS-1:0] cnt0_q, cnt0_d;
  logic [CNT_BITS-1:0] cnt1_q, cnt1_d;

  logic sel0, sel1, xfer0, xfer1;

  assign sel0 = (state_q == BUSY0);
  assign sel1 = (state_q == BUSY1);

  // Only the owner sees the output register's readiness; reset and idle
  // hold both requesters off
  assign s0_ready = reset_n & sel0 & mux_s.ready;
  assign s1_ready = reset_n & sel1 & mux_s.ready;
  assign xfer0    = s0_valid & s0_ready;
  assign xfer1    = s1_valid & s1_ready;

  // Route the owner's beat into the output register
  always_comb begin
    mux_s.data  = '0;
    mux_s.keep  = '0;
    mux_s.last  = 1'b0;
    mux_s.valid = 1'b0;
    if (sel0) begin
      mux_s.data  = s0_data;
      mux_s.keep  = s0_keep;
      mux_s.last  = s0_last;
      mux_s.valid = reset_n & s0_valid;
    end else if (sel1) begin
      mux_s.data  = s1_data;
      mux_s.keep  = s1_keep;
      mux_s.last  = s1_last;
      mux_s.valid = reset_n & s1_valid;
    end
  end

  arb_out_reg #(.DATA_BYTES(DATA_BYTES)) u_out_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .in_s    (mux_s),
    .out_m   (out_s)
  );

  assign out_s.ready = out_ready;
  assign out_data    = out_s.data;
  assign out_keep    = out_s.keep;
  assign out_last    = out_s.last;
  assign out_valid   = out_s.valid;

  // Next owner: decide in idle, release only on the owner's last beat
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) state_d = last_served_q ? BUSY0 : BUSY1;
        else if (s0_valid)        state_d = BUSY0;
        else if (s1_valid)        state_d = BUSY1;
      end
      BUSY0: begin
        if (xfer0 && s0_last) begin
          state_d       = IDLE;
          last_served_d = 1'b0;
          cnt0_d        = cnt0_q + CNT_BITS'(1);
        end
      end
      BUSY1: begin
        if (xfer1 && s1_last) begin
          state_d       = IDLE;
          last_served_d = 1'b1;
          cnt1_d        = cnt1_q + CNT_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = grant_of(state_d);
  end

  // FSM, fairness flag, registered grant and packet counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      grant_q       <= 2'b00;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      grant_q       <= grant_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  assign grant    = grant_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: doc/stream_arb2.md
STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 16, meaning bytes per beat on all ports (1..16).
REQ-002 SHALL have parameter CNT_BITS, default 32, meaning width of per-requester packet counters.
REQ-003 SHALL be one clock; reset is synchronous and active-low (clock, reset_n); polarity and synchronicity are fixed.
REQ-004 SHALL have ports, in this order:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous active-low reset
- s0_data  in  DATA_BYTES*8  requester 0 data
- s0_last  in  1  requester 0 end of packet
- s0_keep  in  DATA_BYTES  requester 0 byte enables
- s0_valid  in  1  requester 0 valid
- s0_ready  out  1  requester 0 ready
- s1_data, s1_last, s1_keep, s1_valid, s1_ready: same widths and meanings for requester 1
- out_data  out  DATA_BYTES*8  merged stream data
- out_last  out  1  merged end of packet
- out_keep  out  DATA_BYTES  merged byte enables
- out_valid  out  1  merged valid
- out_ready  in  1  downstream ready; typically the stream_convert input
- grant  out  2  one-hot owner, 00 when idle
- pkt_cnt0, pkt_cnt1  out  CNT_BITS  completed packets per requester

Function
REQ-005 SHALL implement FSM states IDLE, BUSY0 and BUSY1, and SHALL arbitrate per packet, never per beat.
REQ-006 In IDLE, if only sN_valid is high, the FSM SHALL go to BUSYN on the next edge.
REQ-007 In IDLE, if both valids are high, the FSM SHALL go to the requester not served last; the last_served flag resets to 1, so s0 wins first.
REQ-008 In IDLE, both sN_ready SHALL be 0; the arbitration decision costs exactly one cycle.
REQ-009 In BUSYN, sN_ready SHALL equal (~out_valid | out_ready), and the other ready SHALL be 0; ready is combinational from the output register state.
REQ-010 A beat SHALL transfer when sN_valid & sN_ready; data, last and keep are then registered to the outputs with out_valid=1 on the next edge (latency 1 cycle).
REQ-011 out_valid SHALL clear when out_ready=1 and no new beat loads in the same cycle; a simultaneous load and unload keeps out_valid=1 with new data, giving full throughput with no gap cycles.
REQ-012 out_* SHALL hold stable while out_valid & ~out_ready.
REQ-013 Transfer of a beat with sN_last=1 SHALL move the FSM to IDLE, set last_served=N and increment pkt_cntN on the same edge.
REQ-014 pkt_cntN SHALL wrap modulo 2^CNT_BITS.
REQ-015 grant SHALL be 01 in BUSY0, 10 in BUSY1 and 00 in IDLE.
REQ-016 Keep SHALL pass unmodified; the block performs no keep checking.
REQ-017 A requester dropping valid mid-packet SHALL NOT release the grant; the FSM waits in BUSYN indefinitely.

Reset
REQ-018 With reset_n=0 at an edge, the block SHALL set FSM=IDLE, last_served=1, out_valid=0, out_last=0, out_data=0, out_keep=0, pkt_cnt0=pkt_cnt1=0 and grant=00; both readies are 0 during reset.
REQ-019 Reset mid-packet SHALL discard the partial packet with no out_last emitted; a stalled output beat is dropped.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding (IDLE=0, BUSY0=1, BUSY1=2, 2 bits) and the DATA_BYTES default.
REQ-021 The output register SHALL be one sub-module, arb_out_reg: a one-entry valid/ready register with data width DATA_BYTES*9+1.
REQ-022 Arbitration and counters SHALL live in the top level; no stream_IO instance is used.

Verification
REQ-023 s0 sends a 3-beat packet (data 1,2,3; last on 3), s1 idle, out_ready=1 -> out_data 1,2,3 on consecutive cycles, starting 2 cycles after s0_valid; out_last on beat 3; pkt_cnt0=1; grant 01 then 00.
REQ-024 s0 and s1 both valid from reset with 2-beat packets, repeated -> packet order s0,s1,s0,s1; no beats interleaved within a packet; counters 2/2 after 4 packets.
REQ-025 out_ready toggles 1010... during a 4-beat s1 packet -> all 4 beats delivered in order, none duplicated, out_data stable while stalled.
REQ-026 s0 deasserts valid for 5 cycles mid-packet while s1 is valid -> grant stays 01 and s1_ready=0 until s0's last beat transfers.
REQ-027 reset_n=0 for 1 cycle after beat 2 of a 4-beat packet -> out_valid=0, grant=00 and counters=0 next cycle; a new packet is arbitrated cleanly afterwards with s0 first.
REQ-028 pkt_cnt0 preloaded to 2^CNT_BITS-1 via a reduced CNT_BITS=4 build, then 1 more packet sent -> pkt_cnt0 wraps to 0.
